// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings and default width for the multiply/divide sequencer
package md_pkg;
    localparam int MD_WIDTH = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;
endpackage

// File: rtl/md_divstep.sv
// md_divstep: one combinational restoring-division step on a {rem,quo} pair
module md_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift, w_diff;
    logic w_ge;
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign w_ge    = ~w_diff[WIDTH];
    assign o_rem   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle MIPS mult/multu/div/divu sequencer with HI/LO registers
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    logic [1:0]         r_state, r_op;
    logic [CW-1:0]      r_count;
    logic               r_neg, r_neg_rem, r_zero, r_done;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic               w_a_neg, w_b_neg, w_idle;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_dv_rem, w_dv_quo, w_rem, w_quo;
    logic [WIDTH:0]     w_mul_add;
    logic [2*WIDTH-1:0] w_prod;

    assign w_idle  = r_state == S_IDLE;
    assign w_a_neg = ~op[0] & rs[WIDTH-1];
    assign w_b_neg = ~op[0] & rt[WIDTH-1];
    assign w_a_abs = w_a_neg ? -rs : rs;
    assign w_b_abs = w_b_neg ? -rt : rt;
    // Multiply: r_acc = {partial product, remaining multiplier bits}
    assign w_mul_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    md_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem(r_acc[2*WIDTH-1:WIDTH]),
        .i_quo(r_acc[WIDTH-1:0]),
        .i_div(r_b),
        .o_rem(w_dv_rem),
        .o_quo(w_dv_quo)
    );
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    // Divide by zero forces an all-ones quotient regardless of operand signs
    assign w_quo  = r_zero ? '1 : r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_MULT;
            r_count   <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_zero    <= 1'b0;
            r_done    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc     <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_state   <= S_RUN;
                    r_op      <= op;
                    r_count   <= '0;
                    r_a       <= w_a_abs;
                    r_b       <= w_b_abs;
                    r_neg     <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    r_zero    <= op[1] & (rt == '0);
                    r_acc     <= {{WIDTH{1'b0}}, op[1] ? w_a_abs : w_b_abs};
                end else begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                end
            end else if (r_state == S_RUN) begin
                r_acc   <= r_op[1] ? {w_dv_rem, w_dv_quo} : {w_mul_add, r_acc[WIDTH-1:1]};
                r_count <= r_count + 1'b1;
                if (r_count == CW'(WIDTH-1)) r_state <= S_FIX;
            end else begin
                r_hi    <= r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH];
                r_lo    <= r_op[1] ? w_quo : w_prod[WIDTH-1:0];
                r_done  <= 1'b1;
                r_state <= S_IDLE;
            end
        end
    end

    assign busy = ~w_idle;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: table-driven vectors plus hand-written corner sequences for md_sequencer
module tb_md_sequencer;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = '0, rt = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int checks = 0, failures = 0;

    md_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, ehi, elo;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    // Runs one op; at busy cycle ign_at (if >0) pokes a stray start and mthi/mtlo, which must be ignored
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ign_at);
        logic [31:0] hi0, lo0;
        int nb = 0, nd = 0;
        logic moved = 1'b0;
        hi0 = hi;
        lo0 = lo;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0;
        while (busy && nb < 100) begin
            nb++;
            if (done) nd++;
            if (hi !== hi0 || lo !== lo0) moved = 1'b1;
            if (nb == ign_at) begin
                start = 1'b1; op = ~o; rs = 32'h5; rt = 32'h3;
                mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        chk({tag, "_done_early"}, 64'(nd), 64'd0);
        chk({tag, "_hilo_stable"}, 64'(moved), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        chk({tag, "_done_clear"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{2'b11, 32'h00000014, 32'h00000003, 32'h00000002, 32'h00000006};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'b11, 32'h00000014, 32'h00000000, 32'h00000014, 32'hFFFFFFFF};
        vecs[7]  = '{2'b10, 32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFEC, 32'hFFFFFFFF};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, 0);

        run_op("ignore_busy", 2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 5);

        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000ABCD;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", 64'(hi), 64'h0000ABCD);
        chk("mt_both_lo", 64'(lo), 64'h0000ABCD);

        start = 1'b1; op = 2'b01; rs = 32'd2; rt = 32'd3;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h00005555;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("start_wins_busy", 64'(busy), 64'd1);
        chk("start_wins_hi", 64'(hi), 64'h0000ABCD);
        chk("start_wins_lo", 64'(lo), 64'h0000ABCD);
        wait_done("start_wins");
        chk("start_wins_res_hi", 64'(hi), 64'd0);
        chk("start_wins_res_lo", 64'(lo), 64'd6);
        @(negedge clk);

        start = 1'b1; op = 2'b00; rs = 32'd9; rt = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_busy", 64'(busy), 64'd0);
        chk("mid_reset_done", 64'(done), 64'd0);
        chk("mid_reset_hi", 64'(hi), 64'd0);
        chk("mid_reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_reset", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
